// File: rtl/lpc_pkg.sv
// Shared LPC definitions: host FSM states, sync codes, CT/DIR fields and
// response status codes. Also used by the bus sniffer.
package lpc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_CTDIR,
    ST_ADDR,
    ST_WDATA,
    ST_TAR1,
    ST_SYNC,
    ST_RDATA,
    ST_TAR2,
    ST_ABORT,
    ST_DONE
  } lpc_state_e;

  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_SHORT = 4'b0101;
  localparam logic [3:0] SYNC_LONG  = 4'b0110;
  localparam logic [3:0] SYNC_ERROR = 4'b1010;

  localparam logic [3:0] AD_START = 4'b0000;
  localparam logic [3:0] AD_IDLE  = 4'b1111;

  localparam logic [1:0] CT_IO       = 2'b00;
  localparam logic [1:0] CT_MEM      = 2'b01;
  localparam int         CT_UNSUP_BIT = 3;
  localparam int         CT_DIR_BIT   = 1;

  localparam logic [1:0] STATUS_OK       = 2'b00;
  localparam logic [1:0] STATUS_SYNC_ERR = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT  = 2'b10;
  localparam logic [1:0] STATUS_UNSUP    = 2'b11;

  function automatic logic is_sync_code(input logic [3:0] code);
    return (code == SYNC_READY) || (code == SYNC_SHORT) ||
           (code == SYNC_LONG)  || (code == SYNC_ERROR);
  endfunction

endpackage

// File: rtl/lpc_sync_timer.sv
// SYNC-phase watchdog: counts unrecognised codes and consecutive long waits,
// flagging a timeout on the clock that reaches either limit.
module lpc_sync_timer
  import lpc_pkg::*;
#(
  parameter int SHORT_TIMEOUT = 8,
  parameter int LONG_TIMEOUT  = 255
) (
  input  logic       lpc_clock,
  input  logic       lpc_reset,
  input  logic       active,
  input  logic [3:0] sync_code,
  output logic       timeout
);

  localparam int SW = $clog2(SHORT_TIMEOUT + 1);
  localparam int LW = $clog2(LONG_TIMEOUT + 1);

  logic [SW-1:0] short_cnt;
  logic [LW-1:0] long_cnt;
  logic          is_other;
  logic          is_long;

  assign is_other = !is_sync_code(sync_code);
  assign is_long  = (sync_code == SYNC_LONG);

  assign timeout = active &&
                   ((is_other && (short_cnt == SW'(SHORT_TIMEOUT - 1))) ||
                    (is_long  && (long_cnt  == LW'(LONG_TIMEOUT - 1))));

  // Counters only live while the host is in SYNC
  always_ff @(posedge lpc_clock) begin
    if (lpc_reset || !active) begin
      short_cnt <= '0;
      long_cnt  <= '0;
    end else begin
      if (sync_code == SYNC_SHORT) short_cnt <= '0;
      else if (is_other)           short_cnt <= short_cnt + 1'b1;
      if (is_long) long_cnt <= long_cnt + 1'b1;
      else         long_cnt <= '0;
    end
  end

endmodule

// File: rtl/lpc_host.sv
// LPC host cycle engine: turns one request into an I/O or memory LPC cycle
// and returns read data plus a completion status.
module lpc_host
  import lpc_pkg::*;
#(
  parameter int SHORT_TIMEOUT = 8,
  parameter int LONG_TIMEOUT  = 255
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cyctype_dir,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_data,
  output logic        lpc_frame,
  output logic [3:0]  lpc_ad_out,
  output logic        lpc_ad_oe,
  input  logic [3:0]  lpc_ad_in,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic [1:0]  rsp_status
);

  lpc_state_e  state, state_next;
  logic [2:0]  cnt;
  logic [3:0]  ctdir_q;
  logic [31:0] addr_sr;
  logic [7:0]  wdata_q;
  logic        is_mem, is_write, in_sync, sync_timeout, sync_done, accept;

  assign is_mem    = (ctdir_q[3:2] == CT_MEM);
  assign is_write  = ctdir_q[CT_DIR_BIT];
  assign in_sync   = (state == ST_SYNC);
  assign req_ready = (state == ST_IDLE) && !lpc_reset;
  assign rsp_valid = (state == ST_DONE) && !lpc_reset;
  assign accept    = req_valid && req_ready;
  assign sync_done = in_sync && !sync_timeout &&
                     ((lpc_ad_in == SYNC_READY) || (lpc_ad_in == SYNC_ERROR));

  lpc_sync_timer #(
    .SHORT_TIMEOUT(SHORT_TIMEOUT),
    .LONG_TIMEOUT (LONG_TIMEOUT)
  ) u_sync_timer (
    .lpc_clock(lpc_clock),
    .lpc_reset(lpc_reset),
    .active   (in_sync),
    .sync_code(lpc_ad_in),
    .timeout  (sync_timeout)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = req_cyctype_dir[CT_UNSUP_BIT] ? ST_DONE : ST_START;
      ST_START: state_next = ST_CTDIR;
      ST_CTDIR: state_next = ST_ADDR;
      ST_ADDR:  if (cnt == (is_mem ? 3'd7 : 3'd3)) state_next = is_write ? ST_WDATA : ST_TAR1;
      ST_WDATA: if (cnt == 3'd1) state_next = ST_TAR1;
      ST_TAR1:  if (cnt == 3'd1) state_next = ST_SYNC;
      ST_SYNC: begin
        if (sync_timeout)   state_next = ST_ABORT;
        else if (sync_done) state_next = is_write ? ST_TAR2 : ST_RDATA;
      end
      ST_RDATA: if (cnt == 3'd1) state_next = ST_TAR2;
      ST_TAR2:  if (cnt == 3'd1) state_next = ST_DONE;
      ST_ABORT: if (cnt == 3'd3) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    lpc_frame  = 1'b1;
    lpc_ad_oe  = 1'b0;
    lpc_ad_out = AD_IDLE;
    if (!lpc_reset) begin
      case (state)
        ST_START: begin lpc_frame = 1'b0; lpc_ad_oe = 1'b1; lpc_ad_out = AD_START; end
        ST_CTDIR: begin lpc_ad_oe = 1'b1; lpc_ad_out = ctdir_q; end
        ST_ADDR:  begin lpc_ad_oe = 1'b1; lpc_ad_out = addr_sr[31:28]; end
        ST_WDATA: begin lpc_ad_oe = 1'b1; lpc_ad_out = cnt[0] ? wdata_q[7:4] : wdata_q[3:0]; end
        ST_TAR1:  lpc_ad_oe = (cnt == 3'd0);
        ST_ABORT: begin lpc_frame = 1'b0; lpc_ad_oe = 1'b1; end
        default:  ;
      endcase
    end
  end

  // Control and response registers
  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rsp_data   <= '0;
      rsp_status <= STATUS_OK;
    end else begin
      state <= state_next;
      cnt   <= (state_next != state) ? 3'd0 : cnt + 3'd1;
      if (accept) begin
        rsp_data   <= '0;
        rsp_status <= req_cyctype_dir[CT_UNSUP_BIT] ? STATUS_UNSUP : STATUS_OK;
      end
      if (sync_done && (lpc_ad_in == SYNC_ERROR)) rsp_status <= STATUS_SYNC_ERR;
      if (state == ST_RDATA) begin
        if (cnt == 3'd0) rsp_data[3:0] <= lpc_ad_in;
        else             rsp_data[7:4] <= lpc_ad_in;
      end
      if (state == ST_ABORT) begin
        rsp_status <= STATUS_TIMEOUT;
        rsp_data   <= '0;
      end
    end
  end

  // Request capture; I/O addresses are pre-aligned so both widths shift out of the top
  always_ff @(posedge lpc_clock) begin
    if (accept) begin
      ctdir_q <= req_cyctype_dir;
      addr_sr <= (req_cyctype_dir[3:2] == CT_MEM) ? req_addr : {req_addr[15:0], 16'h0000};
      wdata_q <= req_data;
    end else if (state == ST_ADDR) begin
      addr_sr <= {addr_sr[27:0], 4'h0};
    end
  end

endmodule

// File: tb/tb_lpc_host.sv
// Directed bench for lpc_host: responder behaviour is scripted per cycle and
// host bus nibbles, latency and responses are checked against hand values.
module tb_lpc_host;

  logic        lpc_clock = 1'b0;
  logic        lpc_reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cyctype_dir;
  logic [31:0] req_addr;
  logic [7:0]  req_data;
  logic        lpc_frame;
  logic [3:0]  lpc_ad_out;
  logic        lpc_ad_oe;
  logic [3:0]  lpc_ad_in;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_status;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;

  lpc_host dut (
    .lpc_clock      (lpc_clock),
    .lpc_reset      (lpc_reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_cyctype_dir(req_cyctype_dir),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .lpc_frame      (lpc_frame),
    .lpc_ad_out     (lpc_ad_out),
    .lpc_ad_oe      (lpc_ad_oe),
    .lpc_ad_in      (lpc_ad_in),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_status     (rsp_status)
  );

  always #5 lpc_clock = ~lpc_clock;

  // Drive the responder nibble for the current cycle, then observe the next one
  task automatic step(input logic [3:0] d);
    lpc_ad_in = d;
    @(negedge lpc_clock);
    cyc++;
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) step(4'hf);
  endtask

  task automatic issue(input logic [3:0] ct, input logic [31:0] a, input logic [7:0] d);
    req_cyctype_dir = ct;
    req_addr        = a;
    req_data        = d;
    req_valid       = 1'b1;
    acc_cyc         = cyc;
    step(4'hf);
    req_valid       = 1'b0;
  endtask

  task automatic finish_wait(output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(4'hf);
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
        lat  = cyc - acc_cyc;
      end
    end
  endtask

  task automatic test_reset();
    lpc_reset = 1'b1;
    req_valid = 1'b0;
    req_cyctype_dir = 4'h0;
    req_addr  = 32'h0;
    req_data  = 8'h0;
    lpc_ad_in = 4'hf;
    repeat (3) @(negedge lpc_clock);
    total++;
    if ({lpc_frame, lpc_ad_oe, lpc_ad_out} !== 6'b101111) begin
      bad++; $display("FAIL reset_bus: got %b want 101111", {lpc_frame, lpc_ad_oe, lpc_ad_out});
    end
    total++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_handshake: got ready=%b valid=%b want 0 0", req_ready, rsp_valid);
    end
    total++;
    if ({rsp_data, rsp_status} !== 10'h000) begin
      bad++; $display("FAIL reset_rsp: got %h/%b want 00/00", rsp_data, rsp_status);
    end
    lpc_reset = 1'b0;
    step(4'hf);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_io_read(input string tag);
    logic [5:0] exp[$];
    int lat;
    bit seen;
    exp = '{6'h10, 6'h30, 6'h37, 6'h3f, 6'h3e, 6'h35, 6'h3f};
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL %s_ready: got %b want 1", tag, req_ready);
    end
    issue(4'h0, 32'h0000_7fe5, 8'h00);
    for (int i = 0; i < exp.size(); i++) begin
      if (i > 0) step(4'hf);
      total++;
      if ({lpc_frame, lpc_ad_oe, lpc_ad_out} !== exp[i]) begin
        bad++; $display("FAIL %s_bus%0d: got %h want %h", tag, i, {lpc_frame, lpc_ad_oe, lpc_ad_out}, exp[i]);
      end
    end
    step(4'hf);
    total++;
    if (lpc_ad_oe !== 1'b0) begin
      bad++; $display("FAIL %s_tar1_release: got oe=%b want 0", tag, lpc_ad_oe);
    end
    step(4'hf);
    step(4'h0);
    step(4'hc);
    step(4'h6);
    finish_wait(lat, seen);
    total++;
    if (!seen || lat != 14) begin
      bad++; $display("FAIL %s_latency: got seen=%0d lat=%0d want 1 14", tag, seen, lat);
    end
    total++;
    if (rsp_data !== 8'h6c || rsp_status !== 2'b00) begin
      bad++; $display("FAIL %s_rsp: got %h/%b want 6c/00", tag, rsp_data, rsp_status);
    end
    step(4'hf);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL %s_after_done: got valid=%b ready=%b want 0 1", tag, rsp_valid, req_ready);
    end
  endtask

  task automatic test_io_write();
    logic [5:0] exp[$];
    int lat;
    bit seen;
    exp = '{6'h10, 6'h32, 6'h30, 6'h30, 6'h38, 6'h30, 6'h35, 6'h3a, 6'h3f};
    issue(4'h2, 32'h0000_0080, 8'ha5);
    for (int i = 0; i < exp.size(); i++) begin
      if (i > 0) step(4'hf);
      total++;
      if ({lpc_frame, lpc_ad_oe, lpc_ad_out} !== exp[i]) begin
        bad++; $display("FAIL io_write_bus%0d: got %h want %h", i, {lpc_frame, lpc_ad_oe, lpc_ad_out}, exp[i]);
      end
    end
    step(4'hf);
    step(4'hf);
    step(4'h0);
    finish_wait(lat, seen);
    total++;
    if (!seen || lat != 14 || rsp_status !== 2'b00) begin
      bad++; $display("FAIL io_write_rsp: got seen=%0d lat=%0d st=%b want 1 14 00", seen, lat, rsp_status);
    end
    step(4'hf);
  endtask

  task automatic test_mem_read();
    logic [5:0] exp[$];
    int lat;
    bit seen;
    exp = '{6'h10, 6'h34, 6'h3f, 6'h3f, 6'h3b, 6'h3c, 6'h31, 6'h32, 6'h33, 6'h34, 6'h3f};
    issue(4'h4, 32'hffbc_1234, 8'h00);
    for (int i = 0; i < exp.size(); i++) begin
      if (i > 0) step(4'hf);
      total++;
      if ({lpc_frame, lpc_ad_oe, lpc_ad_out} !== exp[i]) begin
        bad++; $display("FAIL mem_read_bus%0d: got %h want %h", i, {lpc_frame, lpc_ad_oe, lpc_ad_out}, exp[i]);
      end
    end
    step(4'hf);
    step(4'hf);
    for (int i = 0; i < 3; i++) step(4'h6);
    total++;
    if (lpc_ad_oe !== 1'b0 || lpc_frame !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL mem_read_long_wait: got oe=%b frame=%b valid=%b want 0 1 0", lpc_ad_oe, lpc_frame, rsp_valid);
    end
    step(4'h0);
    step(4'hc);
    step(4'h3);
    finish_wait(lat, seen);
    total++;
    if (!seen || lat != 21 || rsp_data !== 8'h3c || rsp_status !== 2'b00) begin
      bad++; $display("FAIL mem_read_rsp: got seen=%0d lat=%0d %h/%b want 1 21 3c/00", seen, lat, rsp_data, rsp_status);
    end
    step(4'hf);
  endtask

  task automatic test_timeout();
    issue(4'h0, 32'h0000_1234, 8'h00);
    skip(8);
    for (int i = 0; i < 7; i++) step(4'hf);
    total++;
    if (lpc_frame !== 1'b1 || lpc_ad_oe !== 1'b0) begin
      bad++; $display("FAIL timeout_early: got frame=%b oe=%b want 1 0 after 7 sync clocks", lpc_frame, lpc_ad_oe);
    end
    step(4'hf);
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({lpc_frame, lpc_ad_oe, lpc_ad_out} !== 6'h1f) begin
        bad++; $display("FAIL timeout_abort%0d: got %h want 1f", k, {lpc_frame, lpc_ad_oe, lpc_ad_out});
      end
      step(4'hf);
    end
    total++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b10 || rsp_data !== 8'h00) begin
      bad++; $display("FAIL timeout_rsp: got valid=%b %h/%b want 1 00/10", rsp_valid, rsp_data, rsp_status);
    end
    step(4'hf);
  endtask

  task automatic test_sync_error();
    int lat;
    bit seen;
    issue(4'h2, 32'h0000_0080, 8'h11);
    skip(10);
    step(4'ha);
    finish_wait(lat, seen);
    total++;
    if (!seen || rsp_status !== 2'b01) begin
      bad++; $display("FAIL sync_error_rsp: got seen=%0d st=%b want 1 01", seen, rsp_status);
    end
    step(4'hf);
  endtask

  task automatic test_unsupported();
    issue(4'h8, 32'h0000_0010, 8'h00);
    total++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b11) begin
      bad++; $display("FAIL unsup_rsp: got valid=%b st=%b want 1 11", rsp_valid, rsp_status);
    end
    total++;
    if (lpc_frame !== 1'b1 || lpc_ad_oe !== 1'b0) begin
      bad++; $display("FAIL unsup_bus: got frame=%b oe=%b want 1 0", lpc_frame, lpc_ad_oe);
    end
    step(4'hf);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || lpc_frame !== 1'b1) begin
      bad++; $display("FAIL unsup_after: got valid=%b ready=%b frame=%b want 0 1 1", rsp_valid, req_ready, lpc_frame);
    end
  endtask

  task automatic test_reset_mid();
    bit stray;
    issue(4'h0, 32'h0000_7fe5, 8'h00);
    skip(2);
    total++;
    if ({lpc_frame, lpc_ad_oe, lpc_ad_out} !== 6'h37) begin
      bad++; $display("FAIL reset_mid_pre: got %h want 37", {lpc_frame, lpc_ad_oe, lpc_ad_out});
    end
    lpc_reset = 1'b1;
    step(4'hf);
    total++;
    if (lpc_frame !== 1'b1 || lpc_ad_oe !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mid_bus: got frame=%b oe=%b valid=%b want 1 0 0", lpc_frame, lpc_ad_oe, rsp_valid);
    end
    lpc_reset = 1'b0;
    step(4'hf);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid_ready: got %b want 1", req_ready);
    end
    stray = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(4'h0);
      if (rsp_valid !== 1'b0 || lpc_frame !== 1'b1) stray = 1'b1;
    end
    total++;
    if (stray) begin
      bad++; $display("FAIL reset_mid_quiet: got stray activity=1 want 0");
    end
  endtask

  initial begin
    test_reset();
    test_io_read("io_read");
    test_io_write();
    test_mem_read();
    test_timeout();
    test_io_read("b2b_read");
    test_sync_error();
    test_unsupported();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion want finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
